// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arb
//  Description : Multi-requester write arbiter for a single FIFO write port.
//                Round-robin arbitration with an optional per-requester lock
//                (burst mode). Write strobe and data to the FIFO are
//                registered (one cycle after the grant). Accepts are
//                throttled by the FIFO full / almost-full flags so that the
//                FIFO never overflows.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ*DW-1:0]        req_data_i,
  input  logic [NREQ-1:0]           req_lock_i,
  output logic [NREQ-1:0]           gnt_o,
  input  logic                      fifo_full_i,
  input  logic                      fifo_almost_full_i,
  output logic                      wr_o,
  output logic [DW-1:0]             data_in_o,
  output logic [$clog2(NREQ)-1:0]   owner_o,
  output logic                      locked_o
);

  localparam int IW = $clog2(NREQ);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q,   ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          wr_q,    wr_d;
  logic [DW-1:0] data_q,  data_d;

  logic          accept_ok_w;
  logic          hold_w;
  logic          found_w;
  logic          grant_w;
  logic [IW-1:0] win_w;
  logic [IW-1:0] idx_w;
  int            idx_int_w;
  logic [DW-1:0] win_data_w;

  // Pick the candidate requester: the lock owner while the lock is held,
  // otherwise the first active requester at or after the round-robin pointer.
  always_comb begin
    // One slot left with a write already in flight means the next beat
    // would overflow, so the FIFO can only take a new beat when that is not
    // the case and it is not already full.
    accept_ok_w = !fifo_full_i && !(fifo_almost_full_i && wr_q);
    // A lock is only held while the owner keeps its lock request up; the
    // cycle it drops is arbitrated round-robin.
    hold_w      = (state_q == S_LOCKED) && req_lock_i[owner_q];
    found_w     = 1'b0;
    win_w       = '0;
    idx_int_w   = 0;
    idx_w       = '0;
    if (hold_w) begin
      found_w = req_i[owner_q];
      win_w   = owner_q;
    end else begin
      // Scan from the far end down so the nearest match to ptr wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx_int_w = (int'(ptr_q) + k) % NREQ;
        idx_w     = IW'(idx_int_w);
        if (req_i[idx_w]) begin
          found_w = 1'b1;
          win_w   = idx_w;
        end
      end
    end
    // Reset suppresses any grant so nothing is accepted while rst is high.
    grant_w = found_w && accept_ok_w && !rst;
  end

  // One-hot grant strobe and selection of the winner's write data.
  always_comb begin
    gnt_o      = '0;
    win_data_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_w == IW'(i)) begin
        win_data_w = req_data_i[i*DW +: DW];
      end
    end
    if (grant_w) begin
      gnt_o[win_w] = 1'b1;
    end
  end

  // Next-state: pointer/owner advance on grant, lock entry/exit, write beat.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    wr_d    = grant_w;
    if (grant_w) begin
      ptr_d   = (win_w == IW'(NREQ - 1)) ? '0 : win_w + 1'b1;
      owner_d = win_w;
      data_d  = win_data_w;
      state_d = req_lock_i[win_w] ? S_LOCKED : S_IDLE;
    end else if (accept_ok_w && !hold_w) begin
      // Lock dropped (or already idle) with nobody granted: fall back to
      // round-robin. Under backpressure the state is left untouched.
      state_d = S_IDLE;
    end
  end

  // State registers with synchronous reset; reset also cancels a pending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  assign wr_o      = wr_q;
  assign data_in_o = data_q;
  assign owner_o   = owner_q;
  assign locked_o  = (state_q == S_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arb
//  Description : Self-checking bench for fifo_wr_arb. A 32-deep FIFO
//                occupancy model drives the full flags; a reference
//                arbitration model predicts grants and queues the expected
//                write data, which a monitor pops on every wr strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   gnt;
  logic              fifo_full;
  logic              fifo_almost_full;
  logic              wr;
  logic [DW-1:0]     data_in;
  logic [1:0]        owner;
  logic              locked;

  // FIFO occupancy model and flag overrides
  int   fifo_cnt;
  logic pop;
  logic f_full;
  logic f_af;

  // Reference model state (state visible after the most recent edge)
  int          m_ptr;
  int          m_owner;
  logic        m_locked;
  logic        m_wr;
  logic [7:0]  m_data;
  logic [7:0]  sb[$];

  int checks;
  int failures;

  fifo_wr_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_i              (req),
    .req_data_i         (req_data),
    .req_lock_i         (req_lock),
    .gnt_o              (gnt),
    .fifo_full_i        (fifo_full),
    .fifo_almost_full_i (fifo_almost_full),
    .wr_o               (wr),
    .data_in_o          (data_in),
    .owner_o            (owner),
    .locked_o           (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_full        = (fifo_cnt >= DEPTH) || f_full;
  assign fifo_almost_full = (fifo_cnt == DEPTH - 1) || f_af;

  // FIFO occupancy: writes from the arbiter, pops from the bench.
  always @(posedge clk) begin
    fifo_cnt <= fifo_cnt + (wr ? 1 : 0) - ((pop && fifo_cnt > 0) ? 1 : 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write beat must match the oldest accepted beat and fit.
  task automatic run_monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (wr === 1'b1) begin
        chk("no_overflow", (fifo_cnt < DEPTH) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_wr", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wr_data", {24'd0, data_in}, {24'd0, e});
        end
      end
    end
  endtask

  // One clock cycle of stimulus plus reference-model prediction.
  task automatic cycle(input logic [3:0] r, input logic [3:0] lk, input logic rs,
                       input logic pp, input logic ffc, input logic afc);
    logic       permit;
    logic       hold;
    int         cand;
    int         idx;
    logic [3:0] exp_g;
    @(posedge clk);
    #1;
    req = r; req_lock = lk; rst = rs; pop = pp; f_full = ffc; f_af = afc;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'($urandom);
    #3;
    chk("wr",      {31'd0, wr},      {31'd0, m_wr});
    chk("data_in", {24'd0, data_in}, {24'd0, m_data});
    chk("owner",   {30'd0, owner},   32'(m_owner));
    chk("locked",  {31'd0, locked},  {31'd0, m_locked});
    cand  = -1;
    hold  = 1'b0;
    permit = 1'b0;
    exp_g = 4'b0000;
    if (!rs) begin
      permit = !fifo_full && !(fifo_almost_full && m_wr);
      hold   = m_locked && lk[m_owner];
      if (hold) begin
        if (r[m_owner]) cand = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (cand < 0 && r[idx]) cand = idx;
        end
      end
      if (permit && cand >= 0) exp_g = 4'(1 << cand);
    end
    chk("gnt", {28'd0, gnt}, {28'd0, exp_g});
    if (rs) begin
      m_ptr = 0; m_owner = 0; m_locked = 1'b0; m_wr = 1'b0; m_data = 8'd0;
    end else if (exp_g != 4'b0000) begin
      m_data   = req_data[cand*DW +: DW];
      sb.push_back(m_data);
      m_ptr    = (cand + 1) % NREQ;
      m_owner  = cand;
      m_locked = lk[cand];
      m_wr     = 1'b1;
    end else begin
      m_wr = 1'b0;
      if (permit && !hold) m_locked = 1'b0;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    fifo_cnt = 0; pop = 1'b0; f_full = 1'b0; f_af = 1'b0;
    rst = 1'b1; req = '0; req_lock = '0; req_data = '0;
    m_ptr = 0; m_owner = 0; m_locked = 1'b0; m_wr = 1'b0; m_data = 8'd0;
    fork
      run_monitor();
    join_none

    // Reset with everyone requesting: no grant while rst is high.
    repeat (3) cycle(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    // Round-robin over all four, first accept right after reset.
    repeat (8) cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    // Sparse requesters: skip idle ones and wrap.
    repeat (6) cycle(4'b0101, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    // All idle: pointer and owner must hold.
    repeat (3) cycle(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Lock scenario: ptr=0, grant 0, then requester 1 locks for 5 beats.
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle(4'b1111, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
    // Owner stops requesting but keeps lock: others are ignored.
    repeat (2) cycle(4'b1101, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
    // Backpressure while locked must not release the lock.
    repeat (2) cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    // Lock drop: round-robin resumes at requester 2.
    repeat (3) cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Almost-full with a write in flight, then full.
    cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset the cycle after a grant.
    cycle(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Drain, then back-to-back beats into the 32-deep FIFO with no reads.
    repeat (40) cycle(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (45) cycle(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fifo_filled", 32'(fifo_cnt), 32'(DEPTH));
    repeat (40) cycle(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with real FIFO pressure, locks and rare resets.
    for (int n = 0; n < 2000; n++) begin
      cycle(4'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
            ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 29) == 0));
    end

    repeat (45) cycle(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
